// File: rtl/wb_pwm_capture_if.sv
// Wishbone slave bus bundle for the PWM capture block (16-bit data, 14-bit word address).
// Signals are named from the slave's side: *_i driven by the master, *_o by the slave.
// Latency: pure wiring. Backpressure: none, the slave answers every strobe with one ack.
interface wb_pwm_capture_if;
    logic        stb_i;   // strobe
    logic        cyc_i;   // bus cycle
    logic        we_i;    // write enable
    logic [13:0] adr_i;   // word address
    logic [15:0] dat_i;   // write data
    logic [15:0] dat_o;   // read data, valid while ack_o=1
    logic        ack_o;   // single-cycle acknowledge

    modport master (
        output stb_i, cyc_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  stb_i, cyc_i, we_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/wb_pwm_capture.sv
// Four-channel PWM high-time / period capture in prescaled ticks behind a Wishbone slave.
// Latency: capture regs update 3 clk after a pin's rising edge; bus ack 1 clk after request.
// Backpressure: none; ack is a single-cycle pulse, never back to back.
// Ports: clk, reset (sync, active-high), wb (slave modport), pwm_in[3:0] async pins,
//        irq (one-cycle pulse per capture event when irq_en=1).
module wb_pwm_capture #(
    parameter int PRESCALE = 200,
    parameter int TIMEOUT  = 25000
) (
    input  logic            clk,
    input  logic            reset,
    wb_pwm_capture_if.slave wb,
    input  logic [3:0]      pwm_in,
    output logic            irq
);
    localparam logic [15:0] PRESC_MAX     = 16'(PRESCALE - 1);
    localparam logic [15:0] TIMEOUT_TICKS = 16'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    logic [15:0]      presc_q;
    logic             tick;
    logic [3:0]       sync1_q, sync2_q, prev_q, rise, fall;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [3:0][15:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
    logic [3:0][15:0] width_q, width_d, period_q, period_d;
    logic [3:0]       capture, lost_set, timeout_hit;
    logic [3:0]       valid_q, valid_d, lost_q, lost_d, ch_en_q, ch_en_d;
    logic             irq_en_q, irq_en_d, ack_q, irq_q;
    logic [15:0]      dat_q, rd_data;
    logic             req, wr_en;
    logic [3:0]       adr;
    logic             unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only adr[3:0] is decoded and only the low register bits are writable.
    assign unused_bits = ^{wb.adr_i[13:4], wb.dat_i[15:9]};

    assign adr   = wb.adr_i[3:0];
    assign req   = wb.stb_i & wb.cyc_i & ~ack_q;
    assign wr_en = req & wb.we_i;

    // Tick prescaler
    assign tick = (presc_q == PRESC_MAX);
    always_ff @(posedge clk) begin
        if (reset) presc_q <= '0;
        else       presc_q <= tick ? 16'd0 : presc_q + 16'd1;
    end

    // Synchronizer and edge-detect history run through reset on purpose: a pin that is
    // already high when reset drops must not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        sync1_q <= pwm_in;
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
    end
    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_comb begin
        for (int n = 0; n < 4; n++) timeout_hit[n] = (per_cnt_q[n] >= TIMEOUT_TICKS);
    end

    // Channel FSM: state register
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (reset) state_q[n] <= ST_IDLE;
            else       state_q[n] <= state_d[n];
        end
    end

    // Channel FSM: next state
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            if (!ch_en_q[n]) begin
                state_d[n] = ST_IDLE;
            end else begin
                case (state_q[n])
                    ST_IDLE: if (rise[n]) state_d[n] = ST_HIGH;
                    ST_HIGH: if (timeout_hit[n]) state_d[n] = ST_IDLE;
                             else if (fall[n]) state_d[n] = ST_LOW;
                    ST_LOW:  if (timeout_hit[n]) state_d[n] = ST_IDLE;
                             else if (rise[n]) state_d[n] = ST_HIGH;
                    default: state_d[n] = ST_IDLE;
                endcase
            end
        end
    end

    // Channel FSM: counters and capture/lost events. A rising edge restarts the counters,
    // so a tick landing in the same cycle is dropped.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            hi_cnt_d[n]  = hi_cnt_q[n];
            per_cnt_d[n] = per_cnt_q[n];
            capture[n]   = 1'b0;
            lost_set[n]  = 1'b0;
            if (!ch_en_q[n] || state_q[n] == ST_IDLE) begin
                hi_cnt_d[n]  = '0;
                per_cnt_d[n] = '0;
            end else if (timeout_hit[n]) begin
                lost_set[n]  = 1'b1;
                hi_cnt_d[n]  = '0;
                per_cnt_d[n] = '0;
            end else if (state_q[n] == ST_LOW && rise[n]) begin
                capture[n]   = 1'b1;
                hi_cnt_d[n]  = '0;
                per_cnt_d[n] = '0;
            end else if (tick) begin
                if (state_q[n] == ST_HIGH) hi_cnt_d[n] = sat_inc(hi_cnt_q[n]);
                per_cnt_d[n] = sat_inc(per_cnt_q[n]);
            end
        end
    end

    // Register file next state: bus writes first, hardware events override (set wins over W1C).
    always_comb begin
        width_d  = width_q;
        period_d = period_q;
        valid_d  = valid_q;
        lost_d   = lost_q;
        ch_en_d  = ch_en_q;
        irq_en_d = irq_en_q;
        if (wr_en && adr == 4'd8) begin
            valid_d = valid_q & ~wb.dat_i[3:0];
            lost_d  = lost_q & ~wb.dat_i[7:4];
        end
        if (wr_en && adr == 4'd9) begin
            ch_en_d  = wb.dat_i[3:0];
            irq_en_d = wb.dat_i[8];
        end
        for (int n = 0; n < 4; n++) begin
            if (capture[n]) begin
                width_d[n]  = hi_cnt_q[n];
                period_d[n] = per_cnt_q[n];
                valid_d[n]  = 1'b1;
                lost_d[n]   = 1'b0;
            end
            if (lost_set[n]) begin
                lost_d[n]  = 1'b1;
                valid_d[n] = 1'b0;
            end
        end
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        if (adr < 4'd8)       rd_data = adr[0] ? period_q[adr[2:1]] : width_q[adr[2:1]];
        else if (adr == 4'd8) rd_data = {8'h00, lost_q, valid_q};
        else if (adr == 4'd9) rd_data = {7'h00, irq_en_q, 4'h0, ch_en_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            width_q   <= '0;
            period_q  <= '0;
            valid_q   <= '0;
            lost_q    <= '0;
            ch_en_q   <= 4'hF;
            irq_en_q  <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            width_q   <= width_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            ch_en_q   <= ch_en_d;
            irq_en_q  <= irq_en_d;
            ack_q     <= req;
            if (req) dat_q <= rd_data;
            irq_q     <= irq_en_q & (|capture);
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;
    assign irq      = irq_q;
endmodule
